// File: rtl/seq_match_logger.sv
// -----------------------------------------------------------------------------
// seq_match_logger
//   Downstream logger for the overlapping 1010 detector's match output.
//   Each match is stamped with a free-running cycle counter and queued in a
//   show-ahead FIFO that a host reader drains over valid/ready. A saturating
//   counter totals all matches, a sticky flag records dropped matches, and a
//   registered interrupt flags a fill level at or above the threshold.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous clear of all state (highest priority)
//   enable       in   1: timestamp runs and matches are captured
//   match_in     in   detector z, sampled every rising edge
//   ts_rd_data   out  timestamp at FIFO head (0 while empty)
//   ts_rd_valid  out  FIFO non-empty
//   ts_rd_ready  in   reader accepts head entry
//   match_count  out  total matches seen, saturating at all-ones
//   fifo_level   out  entries held, 0..DEPTH
//   overflow     out  sticky: a match was dropped because the FIFO was full
//   irq          out  registered interrupt
// -----------------------------------------------------------------------------
module seq_match_logger #(
    parameter int TS_W       = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     enable,
    input  logic                     match_in,
    output logic [TS_W-1:0]          ts_rd_data,
    output logic                     ts_rd_valid,
    input  logic                     ts_rd_ready,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]    DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0]    THRESH_L = LW'(IRQ_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_irq;

    logic             w_event;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [LW-1:0]    w_level_next;
    logic             w_overflow_next;

    assign w_event = enable & match_in;
    assign w_pop   = (r_level != '0) & ts_rd_ready;
    assign w_full  = (r_level == DEPTH_L);
    // A simultaneous pop frees the head slot, so a full FIFO still accepts.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    assign w_overflow_next = r_overflow | w_drop;

    // Storage carries no reset: pointers and level are cleared instead, so no
    // stale entry is ever visible after reset or clr.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else if (clr) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (enable) begin
                r_ts <= r_ts + TS_W'(1);
            end
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level    <= w_level_next;
            r_overflow <= w_overflow_next;
            if (w_event && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_irq <= (w_level_next >= THRESH_L) | w_overflow_next;
        end
    end

    assign ts_rd_valid = (r_level != '0);
    assign ts_rd_data  = ts_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign match_count = r_count;
    assign fifo_level  = r_level;
    assign overflow    = r_overflow;
    assign irq         = r_irq;

endmodule

// File: tb/tb_seq_match_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_match_logger
//   Bench for seq_match_logger. A default-parameter instance is exercised by a
//   hand-computed vector table, then by scoreboard-driven sequences (overflow,
//   full with simultaneous pop, clr, async reset, random traffic). A second
//   small instance (TS_W=4, CNT_W=2, DEPTH=4) covers timestamp wrap and count
//   saturation.
// -----------------------------------------------------------------------------
module tb_seq_match_logger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr, en, m, rdy;
    logic [15:0] ts_rd_data;
    logic        ts_rd_valid;
    logic [15:0] match_count;
    logic [3:0]  fifo_level;
    logic        overflow, irq;

    logic        s_clr, s_en, s_m, s_rdy;
    logic [3:0]  s_data;
    logic        s_valid;
    logic [1:0]  s_count;
    logic [2:0]  s_level;
    logic        s_ovf, s_irq;

    seq_match_logger #(.TS_W(16), .DEPTH(8), .CNT_W(16), .IRQ_THRESH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(en), .match_in(m),
        .ts_rd_data(ts_rd_data), .ts_rd_valid(ts_rd_valid), .ts_rd_ready(rdy),
        .match_count(match_count), .fifo_level(fifo_level),
        .overflow(overflow), .irq(irq)
    );

    seq_match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2), .IRQ_THRESH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .enable(s_en), .match_in(s_m),
        .ts_rd_data(s_data), .ts_rd_valid(s_valid), .ts_rd_ready(s_rdy),
        .match_count(s_count), .fifo_level(s_level),
        .overflow(s_ovf), .irq(s_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        clr;
        logic        en;
        logic        m;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  el;
        logic [15:0] ec;
        logic        ei;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic e, input logic mm, input logic r,
                       input logic v, input logic [15:0] d, input logic [3:0] l,
                       input logic [15:0] cnt, input logic i, input logic o);
        tbl.push_back({c, e, mm, r, v, d, l, cnt, i, o});
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] sb_q[$];
    logic [15:0] sb_ts;
    logic [15:0] sb_cnt;
    logic        sb_ovf;

    task automatic sb_reset();
        sb_q.delete();
        sb_ts  = '0;
        sb_cnt = '0;
        sb_ovf = 1'b0;
    endtask

    task automatic sb_cycle(input logic c, input logic e, input logic mm, input logic r);
        bit pop, full;
        clr = c; en = e; m = mm; rdy = r;
        if (c) begin
            sb_reset();
        end else begin
            full = (sb_q.size() == 8);
            pop  = r && (sb_q.size() != 0);
            if (pop) begin
                chk("head", ts_rd_data, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (e && mm) begin
                if (!full || pop) sb_q.push_back(sb_ts);
                else              sb_ovf = 1'b1;
                if (sb_cnt != 16'hFFFF) sb_cnt = sb_cnt + 16'd1;
            end
            if (e) sb_ts = sb_ts + 16'd1;
        end
        @(posedge clk); #1;
        chk("level", fifo_level, sb_q.size());
        chk("valid", ts_rd_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) chk("data", ts_rd_data, sb_q[0]);
        chk("count", match_count, sb_cnt);
        chk("ovf", overflow, sb_ovf);
        chk("irq", irq, (sb_q.size() >= 4) || sb_ovf);
    endtask

    task automatic s_step(input logic c, input logic e, input logic mm, input logic r);
        s_clr = c; s_en = e; s_m = mm; s_rdy = r;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 0; en = 0; m = 0; rdy = 0;
        s_clr = 0; s_en = 0; s_m = 0; s_rdy = 0;
        sb_reset();

        // Test 1: single pulse at ts=5, then pop.
        for (int i = 0; i < 5; i++) add(0,1,0,0, 0,16'd0,4'd0,16'd0,0,0);
        add(0,1,1,0, 1,16'd5,4'd1,16'd1,0,0);
        add(0,1,0,1, 0,16'd0,4'd0,16'd1,0,0);
        // Test 2: clr with a match (discarded), then pulses at ts=3,5,7,9.
        add(1,1,1,0, 0,16'd0,4'd0,16'd0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,16'd0,4'd0,16'd0,0,0);
        add(0,1,1,0, 1,16'd3,4'd1,16'd1,0,0);
        add(0,1,0,0, 1,16'd3,4'd1,16'd1,0,0);
        add(0,1,1,0, 1,16'd3,4'd2,16'd2,0,0);
        add(0,1,0,0, 1,16'd3,4'd2,16'd2,0,0);
        add(0,1,1,0, 1,16'd3,4'd3,16'd3,0,0);
        add(0,1,0,0, 1,16'd3,4'd3,16'd3,0,0);
        add(0,1,1,0, 1,16'd3,4'd4,16'd4,1,0);
        add(0,0,0,1, 1,16'd5,4'd3,16'd4,0,0);
        add(0,0,0,1, 1,16'd7,4'd2,16'd4,0,0);
        add(0,0,0,1, 1,16'd9,4'd1,16'd4,0,0);
        add(0,0,0,1, 0,16'd0,4'd0,16'd4,0,0);

        #12;
        chk("rst_valid", ts_rd_valid, 0);
        chk("rst_data", ts_rd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_count", match_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_irq", irq, 0);
        chk("rst_s_level", s_level, 0);
        #5 rst_n = 1'b1;

        foreach (tbl[i]) begin
            clr = tbl[i].clr; en = tbl[i].en; m = tbl[i].m; rdy = tbl[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), ts_rd_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("v%0d_data", i), ts_rd_data, tbl[i].ed);
            chk($sformatf("v%0d_level", i), fifo_level, tbl[i].el);
            chk($sformatf("v%0d_count", i), match_count, tbl[i].ec);
            chk($sformatf("v%0d_irq", i), irq, tbl[i].ei);
            chk($sformatf("v%0d_ovf", i), overflow, tbl[i].eo);
        end

        // Test 3: nine events into an 8-deep FIFO with no reader.
        sb_cycle(1,0,0,0);
        for (int i = 0; i < 9; i++) sb_cycle(0,1,1,0);
        chk("t3_level", fifo_level, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_irq", irq, 1);
        chk("t3_count", match_count, 9);
        for (int i = 0; i < 8; i++) sb_cycle(0,0,0,1);
        chk("t3_drained_irq", irq, 1);

        // Test 4: full FIFO, event and pop on the same edge.
        sb_cycle(1,0,0,0);
        for (int i = 0; i < 8; i++) sb_cycle(0,1,1,0);
        sb_cycle(0,1,1,1);
        chk("t4_level", fifo_level, 8);
        chk("t4_ovf", overflow, 0);
        chk("t4_head", ts_rd_data, 1);
        for (int i = 0; i < 8; i++) sb_cycle(0,0,0,1);

        // Test 6: clr with match_in=1 and three entries queued.
        sb_cycle(1,0,0,0);
        for (int i = 0; i < 3; i++) sb_cycle(0,1,1,0);
        sb_cycle(1,1,1,1);
        chk("t6_level", fifo_level, 0);
        chk("t6_valid", ts_rd_valid, 0);
        chk("t6_count", match_count, 0);
        chk("t6_ovf", overflow, 0);
        sb_cycle(0,1,1,0);
        chk("t6_ts_restart", ts_rd_data, 0);

        // Async reset in the middle of a burst.
        for (int i = 0; i < 3; i++) sb_cycle(0,1,1,0);
        en = 0; m = 0; rdy = 0; clr = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", fifo_level, 0);
        chk("arst_valid", ts_rd_valid, 0);
        chk("arst_count", match_count, 0);
        chk("arst_irq", irq, 0);
        #3 rst_n = 1'b1;
        sb_reset();
        sb_cycle(0,1,1,0);
        chk("arst_ts_restart", ts_rd_data, 0);

        // Random traffic through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            sb_cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        en = 0; m = 0; rdy = 0; clr = 0;

        // Test 5: small instance, timestamp wrap and count saturation.
        s_step(1,0,0,0);
        for (int i = 0; i < 15; i++) s_step(0,1,0,0);
        s_step(0,1,1,0);
        chk("t5_level1", s_level, 1);
        chk("t5_ts15", s_data, 15);
        s_step(0,1,1,0);
        chk("t5_level2", s_level, 2);
        chk("t5_head15", s_data, 15);
        chk("t5_count2", s_count, 2);
        chk("t5_irq", s_irq, 1);
        s_step(0,0,0,1);
        chk("t5_ts0", s_data, 0);
        chk("t5_level_pop", s_level, 1);
        for (int i = 0; i < 3; i++) begin
            s_step(0,1,1,1);
            chk($sformatf("t5_sat%0d", i), s_count, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
